// File: rtl/conv_cfg_pkg.sv
// Shared definitions for the convolution-controller configuration master:
// transaction state encoding and the controller's register map.
package conv_cfg_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Convolution controller register byte offsets
  localparam int unsigned REG_START       = 32'd0;
  localparam int unsigned REG_CLEAR       = 32'd4;
  localparam int unsigned REG_STATUS      = 32'd8;
  localparam int unsigned REG_LAST_SUM    = 32'd12;
  localparam int unsigned REG_WIDTH       = 32'd16;
  localparam int unsigned REG_HEIGHT      = 32'd20;
  localparam int unsigned REG_FILTER_BASE = 32'd24;

  // True for the states in which the master waits on the slave and the
  // watchdog must run.
  function automatic logic is_wait_state(input state_t st);
    case (st)
      WR_REQ, WR_RESP, RD_REQ, RD_DATA: is_wait_state = 1'b1;
      default:                          is_wait_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/conv_cfg_watchdog.sv
// Saturating per-phase wait counter. 'expired' is high during the
// TIMEOUT_CYCLES-th enabled cycle since the last clear, so the owner can
// abandon the phase on that edge unless a handshake arrives at the same time.
module conv_cfg_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic axi_clk,
  input  logic axi_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_WIDTH-1:0] LIMIT     = TMR_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TMR_WIDTH-1:0] LAST_WAIT = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] ONE       = TMR_WIDTH'(1);

  logic [TMR_WIDTH-1:0] count_r;

  // Count enabled cycles, restart on clear, hold at the limit
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      count_r <= {TMR_WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {TMR_WIDTH{1'b0}};
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r >= LAST_WAIT);

endmodule

// File: rtl/conv_cfg_axil_master.sv
// AXI4-Lite initiator for the convolution controller's register port.
// Accepts one command at a time on a valid/ready command port, runs the
// matching single-beat write or read, and returns a held response. A
// watchdog bounds every handshake phase so a dead slave yields rsp_err.
module conv_cfg_axil_master
  import conv_cfg_pkg::*;
#(
  parameter int AXI_BUS_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH = 10,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset_n,
  // command / response port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_BUS_WIDTH-1:0]  cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AXI_BUS_WIDTH-1:0]  rsp_rdata,
  output logic                      rsp_err,
  // AXI4-Lite master
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_BUS_WIDTH-1:0]  m_axi_wdata,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_BUS_WIDTH-1:0]  m_axi_rdata,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic                      m_axi_rlast
);

  state_t state_r;

  logic aw_ok_s;
  logic w_ok_s;
  logic state_exit_s;
  logic wd_enable_s;
  logic wd_expired_s;
  logic rlast_unused_s;

  // Single-beat transfers only: last-beat flag carries no information
  assign rlast_unused_s = m_axi_rlast;

  assign wd_enable_s = is_wait_state(state_r);

  // Phase completion: a write channel is finished once its valid has
  // dropped or is being accepted this cycle; exit marks every state change
  // so the watchdog restarts at zero in the next state.
  always_comb begin
    aw_ok_s      = (~m_axi_awvalid) | m_axi_awready;
    w_ok_s       = (~m_axi_wvalid)  | m_axi_wready;
    state_exit_s = 1'b0;
    case (state_r)
      IDLE:    state_exit_s = cmd_valid & cmd_ready;
      WR_REQ:  state_exit_s = (aw_ok_s & w_ok_s) | wd_expired_s;
      WR_RESP: state_exit_s = m_axi_bvalid | wd_expired_s;
      RD_REQ:  state_exit_s = m_axi_arready | wd_expired_s;
      RD_DATA: state_exit_s = m_axi_rvalid | wd_expired_s;
      DONE:    state_exit_s = rsp_ready;
      default: state_exit_s = 1'b1;
    endcase
  end

  conv_cfg_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_WIDTH      (TMR_WIDTH)
  ) u_watchdog (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .clear       (state_exit_s),
    .enable      (wd_enable_s),
    .expired     (wd_expired_s)
  );

  // Transaction sequencer with all port outputs registered
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state_r       <= IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= {AXI_BUS_WIDTH{1'b0}};
      m_axi_awaddr  <= {AXI_ADDR_WIDTH{1'b0}};
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= {AXI_BUS_WIDTH{1'b0}};
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= {AXI_ADDR_WIDTH{1'b0}};
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state_r       <= WR_REQ;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state_r       <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // Address and data channels complete independently
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
          end
          if (aw_ok_s && w_ok_s) begin
            m_axi_bready <= 1'b1;
            state_r      <= WR_RESP;
          end else if (wd_expired_s) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_rdata     <= {AXI_BUS_WIDTH{1'b0}};
            state_r       <= DONE;
          end
        end

        WR_RESP: begin
          // bready stays high the whole state so a 1-cycle bvalid is caught
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b0;
            rsp_rdata    <= {AXI_BUS_WIDTH{1'b0}};
            state_r      <= DONE;
          end else if (wd_expired_s) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b1;
            rsp_rdata    <= {AXI_BUS_WIDTH{1'b0}};
            state_r      <= DONE;
          end
        end

        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state_r       <= RD_DATA;
          end else if (wd_expired_s) begin
            m_axi_arvalid <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_rdata     <= {AXI_BUS_WIDTH{1'b0}};
            state_r       <= DONE;
          end
        end

        RD_DATA: begin
          // rready stays high the whole state so a 1-cycle rvalid is caught
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            state_r      <= DONE;
          end else if (wd_expired_s) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b1;
            rsp_rdata    <= {AXI_BUS_WIDTH{1'b0}};
            state_r      <= DONE;
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {AXI_BUS_WIDTH{1'b0}};
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end

        default: begin
          state_r       <= IDLE;
          cmd_ready     <= 1'b1;
          rsp_valid     <= 1'b0;
          rsp_err       <= 1'b0;
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_cfg_axil_master.sv
// Self-checking bench for conv_cfg_axil_master. A bench-side slave answers
// each transaction after chosen delays; the expected per-cycle behaviour is
// derived from phase lengths (handshake cycles, timeout budget, response
// hold) rather than from the design's state machine.
module tb_conv_cfg_axil_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          axi_clk;
  logic          axi_reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          m_axi_rlast;

  int checks;
  int failures;

  conv_cfg_axil_master #(
    .AXI_BUS_WIDTH  (DW),
    .AXI_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_reset_n   (axi_reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rlast   (m_axi_rlast)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Control/status outputs packed for one-shot comparison:
  // {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, cmd_ready}
  function automatic logic [7:0] ctl_vec();
    return {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
            m_axi_rready, rsp_valid, rsp_err, cmd_ready};
  endfunction

  task automatic drive_quiet();
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_addr      = '0;
    cmd_wdata     = '0;
    rsp_ready     = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
  endtask

  // One command through the design against a slave that accepts AW after
  // a_w extra cycles, W after w_w, and pulses B/R r_w cycles after the
  // response-phase ready rises. The requester holds off rsp_ready for
  // 'hold' cycles, optionally presenting a competing command meanwhile.
  task automatic run_txn(input string name, input bit wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                         input logic [DW-1:0] rdat, input int a_w, input int w_w,
                         input int r_w, input int hold, input bit spam);
    int a_c, w_c, q_c, r_c, p_c, rsp_c, last_c;
    bit err;
    bit awv, wv, brd, arv, rrd, rv, re, cr;
    logic [DW-1:0] exp_rd;
    logic [7:0] exp_v, got_v;

    a_c = a_w + 1;
    w_c = wr ? (w_w + 1) : a_c;
    q_c = (a_c > w_c) ? a_c : w_c;
    if (q_c > TO) begin
      err   = 1'b1;
      rsp_c = TO + 1;
      r_c   = 1 << 20;
    end else begin
      r_c   = q_c + 1;
      err   = (r_w >= TO);
      rsp_c = err ? (r_c + TO) : (r_c + r_w + 1);
    end
    p_c    = r_c + r_w;
    exp_rd = (err || wr) ? '0 : rdat;
    last_c = rsp_c + hold + 1;

    @(negedge axi_clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready got=%b exp=1", name, cmd_ready);
    end
    cmd_valid     = 1'b1;
    cmd_write     = wr;
    cmd_addr      = addr;
    cmd_wdata     = wdat;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_rvalid  = 1'b0;

    for (int c = 1; c <= last_c; c++) begin
      @(negedge axi_clk);
      if (c < last_c) begin
        awv = wr && (c <= a_c) && (c < rsp_c);
        wv  = wr && (c <= w_c) && (c < rsp_c);
        brd = wr && (c >= r_c) && (c < rsp_c);
        arv = !wr && (c <= a_c) && (c < rsp_c);
        rrd = !wr && (c >= r_c) && (c < rsp_c);
        rv  = (c >= rsp_c);
        re  = rv && err;
        cr  = 1'b0;
      end else begin
        {awv, wv, brd, arv, rrd, rv, re} = 7'b0000000;
        cr = 1'b1;
      end
      exp_v = {awv, wv, brd, arv, rrd, rv, re, cr};
      got_v = ctl_vec();
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s ctl cyc=%0d got=%b exp=%b", name, c, got_v, exp_v);
      end
      if (awv) begin
        checks++;
        if (m_axi_awaddr !== addr) begin
          failures++;
          $display("FAIL %s awaddr cyc=%0d got=%h exp=%h", name, c, m_axi_awaddr, addr);
        end
      end
      if (wv) begin
        checks++;
        if (m_axi_wdata !== wdat) begin
          failures++;
          $display("FAIL %s wdata cyc=%0d got=%h exp=%h", name, c, m_axi_wdata, wdat);
        end
      end
      if (arv) begin
        checks++;
        if (m_axi_araddr !== addr) begin
          failures++;
          $display("FAIL %s araddr cyc=%0d got=%h exp=%h", name, c, m_axi_araddr, addr);
        end
      end
      if (rv) begin
        checks++;
        if (rsp_rdata !== exp_rd) begin
          failures++;
          $display("FAIL %s rsp_rdata cyc=%0d got=%h exp=%h", name, c, rsp_rdata, exp_rd);
        end
      end
      // slave and requester stimulus for this cycle
      m_axi_awready = wr && (c == a_c);
      m_axi_wready  = wr && (c == w_c);
      m_axi_arready = !wr && (c == a_c);
      m_axi_bvalid  = wr && (c == p_c);
      m_axi_rvalid  = !wr && (c == p_c);
      m_axi_rdata   = (c == p_c) ? rdat : $urandom;
      rsp_ready     = (c == rsp_c + hold);
      cmd_valid     = spam && (c >= rsp_c) && (c < rsp_c + hold);
      cmd_write     = 1'b1;
      cmd_addr      = AW'($urandom_range(0, 255));
      cmd_wdata     = $urandom;
    end
    drive_quiet();
  endtask

  task automatic test_reset();
    logic [7:0] got_v;
    axi_reset_n = 1'b0;
    drive_quiet();
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    got_v = ctl_vec();
    checks++;
    if (got_v !== 8'b00000001) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=%b", got_v, 8'b00000001);
    end
    checks++;
    if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, rsp_rdata} !== {(2 * AW + 2 * DW){1'b0}}) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", m_axi_awaddr, m_axi_araddr,
               m_axi_wdata, rsp_rdata);
    end
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    got_v = ctl_vec();
    checks++;
    if (got_v !== 8'b00000001) begin
      failures++;
      $display("FAIL post_reset_ctl got=%b exp=%b", got_v, 8'b00000001);
    end
  endtask

  task automatic test_write_basic();
    run_txn("wr_width", 1'b1, 10'd16, 32'd5, 32'd0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_read_basic();
    run_txn("rd_status", 1'b0, 10'd8, 32'd0, 32'd3, 0, 0, 2, 0, 1'b0);
    run_txn("rd_min_lat", 1'b0, 10'd12, 32'd0, 32'hCAFE_0001, 0, 0, 1, 0, 1'b0);
  endtask

  task automatic test_aw_stall();
    run_txn("aw_stall", 1'b1, 10'd24, 32'h1234_5678, 32'd0, 5, 0, 0, 0, 1'b0);
    run_txn("w_stall", 1'b1, 10'd28, 32'h0BAD_F00D, 32'd0, 0, 3, 1, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("b_timeout", 1'b1, 10'd0, 32'd1, 32'd0, 0, 0, 100, 0, 1'b0);
    run_txn("after_to", 1'b1, 10'd4, 32'd1, 32'd0, 0, 0, 0, 0, 1'b0);
    run_txn("b_edge_ok", 1'b1, 10'd20, 32'd7, 32'd0, 0, 0, TO - 1, 0, 1'b0);
    run_txn("r_edge_ok", 1'b0, 10'd8, 32'd0, 32'h55AA_55AA, 0, 0, TO - 1, 0, 1'b0);
    run_txn("r_edge_to", 1'b0, 10'd8, 32'd0, 32'h55AA_55AA, 0, 0, TO, 0, 1'b0);
    run_txn("ar_edge_ok", 1'b0, 10'd12, 32'd0, 32'h0000_0042, TO - 1, 0, 1, 0, 1'b0);
    run_txn("ar_timeout", 1'b0, 10'd12, 32'd0, 32'h0000_0042, 1000, 0, 1, 0, 1'b0);
    run_txn("aw_timeout", 1'b1, 10'd16, 32'd9, 32'd0, 1000, 0, 0, 0, 1'b0);
  endtask

  task automatic test_rsp_hold();
    run_txn("rsp_hold", 1'b0, 10'd8, 32'd0, 32'hDEAD_BEEF, 0, 0, 1, 10, 1'b1);
  endtask

  task automatic test_random();
    bit wr;
    int r_w;
    for (int i = 0; i < 24; i++) begin
      wr  = 1'($urandom_range(0, 1));
      r_w = wr ? $urandom_range(0, 4) : $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) r_w = TO + $urandom_range(0, 3);
      run_txn("random", wr, AW'($urandom_range(0, 63) * 4), $urandom, $urandom,
              $urandom_range(0, 4), $urandom_range(0, 4), r_w,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got_v;
    @(negedge axi_clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'd12;
    @(negedge axi_clk);
    cmd_valid     = 1'b0;
    m_axi_arready = 1'b1;
    @(negedge axi_clk);
    m_axi_arready = 1'b0;
    checks++;
    if (m_axi_rready !== 1'b1) begin
      failures++;
      $display("FAIL mid_rready got=%b exp=1", m_axi_rready);
    end
    axi_reset_n = 1'b0;
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    got_v = ctl_vec();
    checks++;
    if (got_v !== 8'b00000001) begin
      failures++;
      $display("FAIL mid_reset_ctl got=%b exp=%b", got_v, 8'b00000001);
    end
    checks++;
    if (m_axi_araddr !== '0) begin
      failures++;
      $display("FAIL mid_reset_araddr got=%h exp=0", m_axi_araddr);
    end
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = 32'h7777_7777;
    @(negedge axi_clk);
    m_axi_rvalid = 1'b0;
    got_v = ctl_vec();
    checks++;
    if (got_v !== 8'b00000001) begin
      failures++;
      $display("FAIL late_rvalid_ctl got=%b exp=%b", got_v, 8'b00000001);
    end
    checks++;
    if (rsp_rdata !== '0) begin
      failures++;
      $display("FAIL late_rvalid_rdata got=%h exp=0", rsp_rdata);
    end
    run_txn("after_reset", 1'b1, 10'd20, 32'd3, 32'd0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_aw_stall();
    test_timeout();
    test_rsp_hold();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
